// File: rtl/enemy_bullet_scheduler.sv
// enemy_bullet_scheduler
//   Owns the enemy bullet pool. It grants enemy fire requests round-robin, at
//   most one per cycle, and places each granted shot in the lowest free slot.
//   On each frame move tick it moves live bullets down the screen. Bullets are
//   retired when they pass the screen bottom or when collision logic kills them.
//
// Ports
//   i_Clk            system clock, rising edge
//   i_Rst_n          synchronous active-low reset
//   i_FireReq        per-requester fire request, held until granted
//   i_FirePos        per-requester spawn position {x[9:0], y[8:0]}
//   o_FireGnt        registered one-hot grant, one cycle wide
//   i_MoveTick       once-per-frame move pulse
//   i_HitKill        per-slot kill from collision logic
//   o_BulletState    registered slot active flags
//   o_BulletPosition registered slot positions {x[9:0], y[8:0]}
//   o_ActiveCount    number of active slots
//   o_Full           all slots active
module enemy_bullet_scheduler #(
    parameter int NUM_REQ  = 15,
    parameter int NUM_SLOT = 31,
    parameter int SCREEN_H = 480,
    parameter int STEP     = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [NUM_REQ-1:0]     i_FireReq,
    input  logic [NUM_REQ*19-1:0]  i_FirePos,
    output logic [NUM_REQ-1:0]     o_FireGnt,
    input  logic                   i_MoveTick,
    input  logic [NUM_SLOT-1:0]    i_HitKill,
    output logic [NUM_SLOT-1:0]    o_BulletState,
    output logic [NUM_SLOT*19-1:0] o_BulletPosition,
    output logic [5:0]             o_ActiveCount,
    output logic                   o_Full
);

    localparam int POS_W  = 19;
    localparam int Y_W    = 9;
    localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W  = REQ_W + 1;
    localparam int SLOT_W = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;

    logic [NUM_SLOT-1:0]       state_q, state_d;
    logic [NUM_SLOT*POS_W-1:0] pos_q, pos_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic [REQ_W-1:0]          ptr_q, ptr_d;

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   search_idx;
    logic               req_found;
    logic [REQ_W-1:0]   win_req;
    logic               slot_found;
    logic [SLOT_W-1:0]  free_slot;
    logic               win;
    logic [POS_W-1:0]   spawn_pos;
    logic [9:0]         new_y;
    logic [5:0]         active_cnt;

    // Round-robin search starting at the pointer. A requester whose grant is
    // visible this cycle is masked, so its still-high request is not granted twice.
    always_comb begin
        eligible   = i_FireReq & ~gnt_q;
        req_found  = 1'b0;
        win_req    = '0;
        search_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            search_idx = {1'b0, ptr_q} + IDX_W'(i);
            if (search_idx >= IDX_W'(NUM_REQ)) begin
                search_idx = search_idx - IDX_W'(NUM_REQ);
            end
            if (!req_found && eligible[search_idx[REQ_W-1:0]]) begin
                req_found = 1'b1;
                win_req   = search_idx[REQ_W-1:0];
            end
        end
    end

    // Lowest free slot. Allocation uses the pre-edge state, so a slot freed
    // this cycle can only be reused on the following cycle.
    always_comb begin
        slot_found = 1'b0;
        free_slot  = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            if (!slot_found && !state_q[s]) begin
                slot_found = 1'b1;
                free_slot  = SLOT_W'(s);
            end
        end
    end

    always_comb begin
        spawn_pos = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (REQ_W'(r) == win_req) begin
                spawn_pos = i_FirePos[POS_W*r +: POS_W];
            end
        end
    end

    assign win = req_found & slot_found;

    always_comb begin
        gnt_d = '0;
        ptr_d = ptr_q;
        if (win) begin
            gnt_d[win_req] = 1'b1;
            ptr_d = (win_req == REQ_W'(NUM_REQ - 1)) ? '0 : win_req + 1'b1;
        end
    end

    // Per-slot update. A kill takes priority over movement. The y sum is 10 bits
    // wide, so a bullet near y=511 is retired and never wraps to the top.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        new_y   = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            if (state_q[s]) begin
                if (i_HitKill[s]) begin
                    state_d[s] = 1'b0;
                end else if (i_MoveTick) begin
                    new_y = {1'b0, pos_q[POS_W*s +: Y_W]} + 10'(STEP);
                    if (new_y >= 10'(SCREEN_H)) begin
                        state_d[s] = 1'b0;
                    end else begin
                        pos_d[POS_W*s +: Y_W] = new_y[Y_W-1:0];
                    end
                end
            end else if (win && (free_slot == SLOT_W'(s))) begin
                // A freshly spawned bullet is loaded as-is, even on a move tick.
                state_d[s]              = 1'b1;
                pos_d[POS_W*s +: POS_W] = spawn_pos;
            end
        end
    end

    always_comb begin
        active_cnt = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            active_cnt = active_cnt + 6'(state_q[s]);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= '0;
            pos_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_FireGnt        = gnt_q;
    assign o_BulletState    = state_q;
    assign o_BulletPosition = pos_q;
    assign o_ActiveCount    = active_cnt;
    assign o_Full           = (active_cnt == 6'(NUM_SLOT));

endmodule

// File: tb/tb_enemy_bullet_scheduler.sv
// Testbench for enemy_bullet_scheduler. Stimulus pushes the grant it expects
// (requester, slot, spawn position) into a queue. A negedge monitor pops one
// entry for every grant the DUT shows. Directed checks cover the pool,
// movement and reset behaviour. A second instance with STEP=15 shares the
// inputs and is checked only for large-step retirement.
module tb_enemy_bullet_scheduler;

    localparam int NR = 15;
    localparam int NS = 31;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     fire_req;
    logic [NR*19-1:0]  fire_pos;
    logic [NR-1:0]     gnt;
    logic              move_tick;
    logic [NS-1:0]     hit_kill;
    logic [NS-1:0]     state;
    logic [NS*19-1:0]  bpos_v;
    logic [5:0]        count;
    logic              full;

    logic [NR-1:0]     d15_gnt;
    logic [NS-1:0]     d15_state;
    logic [NS*19-1:0]  d15_pos;
    logic [5:0]        d15_count;
    logic              d15_full;

    always #5 clk = ~clk;

    enemy_bullet_scheduler #(.NUM_REQ(NR), .NUM_SLOT(NS), .SCREEN_H(480), .STEP(1)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_FireReq(fire_req), .i_FirePos(fire_pos),
        .o_FireGnt(gnt), .i_MoveTick(move_tick), .i_HitKill(hit_kill),
        .o_BulletState(state), .o_BulletPosition(bpos_v), .o_ActiveCount(count), .o_Full(full)
    );

    enemy_bullet_scheduler #(.NUM_REQ(NR), .NUM_SLOT(NS), .SCREEN_H(480), .STEP(15)) dut15 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_FireReq(fire_req), .i_FirePos(fire_pos),
        .o_FireGnt(d15_gnt), .i_MoveTick(move_tick), .i_HitKill(hit_kill),
        .o_BulletState(d15_state), .o_BulletPosition(d15_pos), .o_ActiveCount(d15_count),
        .o_Full(d15_full)
    );

    typedef struct {
        int          req;
        int          slot;
        logic [18:0] pos;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    function automatic logic [18:0] mkpos(input int x, input int y);
        return {10'(x), 9'(y)};
    endfunction

    function automatic logic [18:0] bpos(input int s);
        return bpos_v[19*s +: 19];
    endfunction

    function automatic logic [18:0] d15_bpos(input int s);
        return d15_pos[19*s +: 19];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One clock; afterwards drop requests that were just granted and clear pulses.
    task automatic step();
        @(posedge clk);
        #1;
        fire_req  = fire_req & ~gnt;
        move_tick = 1'b0;
        hit_kill  = '0;
    endtask

    task automatic request(input int r, input logic [18:0] p, input int slot);
        fire_pos[19*r +: 19] = p;
        fire_req[r]          = 1'b1;
        sb_q.push_back('{r, slot, p});
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        fire_req = '0;
        step();
        rst_n    = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t          e;
        logic [NR-1:0] g;
        if (mon_en && (gnt != '0)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant got=%0h exp=none", gnt);
            end else begin
                e    = sb_q.pop_front();
                g    = '0;
                g[e.req] = 1'b1;
                check("grant_onehot", 32'(gnt), 32'(g));
                check("grant_slot_active", 32'(state[e.slot]), 32'd1);
                check("grant_slot_pos", 32'(bpos(e.slot)), 32'(e.pos));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        fire_req  = '0;
        fire_pos  = '0;
        move_tick = 1'b0;
        hit_kill  = '0;
        step();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        check("reset_state", 32'(state), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_full", 32'(full), 32'd0);
        check("reset_pos_zero", 32'(|bpos_v), 32'd0);

        // Single request
        request(3, mkpos(100, 20), 0);
        step();
        check("single_count", 32'(count), 32'd1);
        check("single_state", 32'(state), 32'd1);
        step();
        step();
        check("single_no_regrant", 32'(gnt), 32'd0);
        check("single_count_hold", 32'(count), 32'd1);

        // Round robin from pointer 0, then wrap back to 0
        do_reset();
        request(0, mkpos(5, 30), 0);
        request(5, mkpos(200, 40), 1);
        request(14, mkpos(600, 60), 2);
        step(); step(); step();
        check("rr_count3", 32'(count), 32'd3);
        request(0, mkpos(6, 31), 3);
        request(5, mkpos(201, 41), 4);
        step(); step();
        check("rr_state5", 32'(state), 32'h1f);
        step();
        check("rr_idle", 32'(gnt), 32'd0);

        // Move and retire
        do_reset();
        request(1, mkpos(50, 478), 0);
        request(2, mkpos(60, 470), 1);
        request(3, mkpos(70, 464), 2);
        step(); step(); step();
        move_tick = 1'b1;
        step();
        check("move_pos0_479", 32'(bpos(0)), 32'(mkpos(50, 479)));
        check("move_pos1", 32'(bpos(1)), 32'(mkpos(60, 471)));
        check("move_pos2", 32'(bpos(2)), 32'(mkpos(70, 465)));
        check("move_state", 32'(state), 32'h7);
        check("step15_state", 32'(d15_state), 32'h4);
        check("step15_pos2_479", 32'(d15_bpos(2)), 32'(mkpos(70, 479)));
        check("step15_count", 32'(d15_count), 32'd1);
        move_tick = 1'b1;
        step();
        check("retire_state", 32'(state), 32'h6);
        check("retire_count", 32'(count), 32'd2);
        check("retire_pos_held", 32'(bpos(0)), 32'(mkpos(50, 479)));
        check("step15_retire", 32'(d15_count), 32'd0);
        request(4, mkpos(80, 511), 0);
        step();
        move_tick = 1'b1;
        step();
        check("y511_retire_state", 32'(state), 32'h6);
        check("y511_pos1", 32'(bpos(1)), 32'(mkpos(60, 473)));
        check("y511_pos2", 32'(bpos(2)), 32'(mkpos(70, 467)));
        check("y511_count", 32'(count), 32'd2);

        // Full pool
        do_reset();
        for (int k = 0; k < NS; k++) begin
            request(k % NR, mkpos(k, k + 100), k);
            step();
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd31);
        request(2, mkpos(777, 7), 7);
        step(); step(); step();
        check("full_blocked", 32'(full), 32'd1);
        hit_kill[7] = 1'b1;
        step();
        check("full_after_kill", 32'(full), 32'd0);
        check("full_kill_count", 32'(count), 32'd30);
        step();
        check("full_refill", 32'(full), 32'd1);
        check("full_refill_pos7", 32'(bpos(7)), 32'(mkpos(777, 7)));

        // Simultaneous kill, move and allocation
        do_reset();
        request(0, mkpos(1, 100), 0);
        request(1, mkpos(2, 10), 1);
        step(); step();
        request(2, mkpos(3, 50), 2);
        move_tick   = 1'b1;
        hit_kill[0] = 1'b1;
        step();
        check("simul_state", 32'(state), 32'h6);
        check("simul_pos0_held", 32'(bpos(0)), 32'(mkpos(1, 100)));
        check("simul_pos1_moved", 32'(bpos(1)), 32'(mkpos(2, 11)));
        check("simul_pos2_unmoved", 32'(bpos(2)), 32'(mkpos(3, 50)));

        // Reset mid-operation with pointer away from 0
        do_reset();
        for (int r = 0; r < 10; r++) begin
            request(r, mkpos(r + 300, r + 1), r);
        end
        for (int k = 0; k < 10; k++) begin
            step();
        end
        check("midrst_count10", 32'(count), 32'd10);
        rst_n = 1'b0;
        request(12, mkpos(412, 12), 1);
        request(4, mkpos(404, 4), 0);
        // Grant order after reset starts at requester 0, so 4 precedes 12.
        sb_q.delete(sb_q.size() - 1);
        sb_q.delete(sb_q.size() - 1);
        sb_q.push_back('{4, 0, mkpos(404, 4)});
        sb_q.push_back('{12, 1, mkpos(412, 12)});
        step();
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        step(); step();
        check("midrst_regrant_count", 32'(count), 32'd2);
        step();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_bullet_scheduler.md
Name: enemy_bullet_scheduler

Overview:
- Owns the enemy bullet pool: allocates free bullet slots to enemy fire requests, advances live bullets on the frame move tick, and retires bullets that leave the screen bottom or are killed by a hit.
- Round-robin arbitration across enemy requesters, at most one grant per cycle.
- Feeds o_BulletState / o_BulletPosition to the renderer and collision logic.
- Position format (19 bits): [18:9] x (10 bits), [8:0] y (9 bits).

Parameters:
- NUM_REQ, 15, number of enemy requesters.
- NUM_SLOT, 31, enemy bullet slots in the pool.
- SCREEN_H, 480, y value at or beyond which a bullet is retired.
- STEP, 1, y increment per move tick (1..15).

Ports:
- i_Clk  input  1  system clock, all logic on rising edge.
- i_Rst_n  input  1  synchronous active-low reset.
- i_FireReq  input  NUM_REQ  per-enemy fire request; held high until granted.
- i_FirePos  input  NUM_REQ*19  spawn position per requester; requester r uses bits [19r+18:19r].
- o_FireGnt  output  NUM_REQ  registered one-hot grant, high for one cycle.
- i_MoveTick  input  1  single-cycle pulse, once per frame.
- i_HitKill  input  NUM_SLOT  per-slot kill from collision logic.
- o_BulletState  output  NUM_SLOT  slot active flags (registered).
- o_BulletPosition  output  NUM_SLOT*19  slot positions; slot s at [19s+18:19s] (registered).
- o_ActiveCount  output  6  popcount of o_BulletState (combinational from the state register).
- o_Full  output  1  high when all NUM_SLOT slots are active.

Behaviour:
- Reset (i_Rst_n low at an edge): o_BulletState=0, all positions=0, o_FireGnt=0, RR pointer=0. Overrides every other input in that cycle. Mid-operation reset drops all bullets and any pending grant.
- Eligible requesters: i_FireReq[r]=1 AND o_FireGnt[r]=0. This masks a requester in the cycle it sees its grant, so one request produces exactly one grant.
- Arbitration: search starts at the RR pointer and wraps modulo NUM_REQ. The first eligible requester r wins, but only if at least one free slot exists, judged on the current-cycle o_BulletState.
- On a win at edge k:
  - o_FireGnt becomes one-hot r during cycle k+1.
  - The lowest-index free slot s is loaded with i_FirePos[r] and state[s] is set to 1.
  - Pointer becomes (r+1) mod NUM_REQ.
- No win (no eligible requester, or pool full): o_FireGnt=0, pointer unchanged, requests stay pending.
- Latency: request sampled at edge k -> grant visible and bullet active in cycle k+1.
- Per-slot update, for active slots at each edge, in priority order:
  1. i_HitKill[s]=1 -> state[s] cleared; position holds its value.
  2. Else if i_MoveTick=1: new_y = y + STEP, computed at 10 bits. If new_y >= SCREEN_H, state cleared and position held; else y updated, x unchanged.
  3. Else hold.
- i_HitKill and i_MoveTick on inactive slots are ignored.
- A slot freed in cycle k is not re-allocatable until cycle k+1, because allocation uses pre-edge state.
- A bullet allocated at the same edge as i_MoveTick is loaded unmoved with i_FirePos.
- i_HitKill on the slot being allocated cannot occur, since that slot was inactive; it is ignored.
- y never wraps: the 10-bit sum guarantees retire instead of overflow at y=511.
- Spawn positions are not range-checked. A spawn with y >= SCREEN_H is retired on the next move tick.
- o_Full = (o_ActiveCount == NUM_SLOT).

Test Plan:
- Reset then single request: i_FireReq[3]=1, i_FirePos[3]={10'd100,9'd20} -> next cycle o_FireGnt=0x0008, slot0 active at {100,20}, o_ActiveCount=1. Requester drops req -> no second grant.
- Round-robin: reqs 0, 5 and 14 held high from pointer=0 -> grants 0, 5, 14 in consecutive cycles, filling slots 0, 1, 2. Re-raise 0 and 5 with pointer=15 mod 15=0 -> order 0 then 5.
- Move/retire: slot at y=478 with STEP=1 -> tick gives y=479, still active. Next tick -> retired, o_ActiveCount decrements. With STEP=15 at y=470 -> retired on one tick.
- Full pool: fill 31 slots, o_Full=1, req 2 held -> no grant. i_HitKill[7]=1 -> next cycle o_Full=0. Following edge grants req 2 into slot 7.
- Simultaneous events: same cycle as i_MoveTick, i_HitKill[0]=1 on slot0, slot1 at y=10, new grant into slot2 at y=50 -> slot0 cleared, slot1 y=11, slot2 y=50 (unmoved).
- Reset mid-operation: 10 active bullets, pending requests, i_Rst_n=0 for one edge -> all states 0, o_FireGnt=0, count 0. Pointer 0, so first grant after release goes to the lowest-index pending requester.
